// File: rtl/sequencer_pkg.sv
// Shared types, opcode constants and control-word tables for the 4-bit
// microcontroller sequencer and its datapath.
package sequencer_pkg;

    localparam int PC_W = 5;
    localparam int OP_W = 4;
    localparam int CW_W = 16;
    localparam logic [PC_W-1:0] PROG_LAST = 5'd31;

    typedef logic [CW_W-1:0] cword_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC1,
        S_EXEC2,
        S_HALTED
    } state_t;

    typedef enum logic {
        MODE_STEP,
        MODE_RUN
    } mode_t;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    // Control-word bit positions, shared with the datapath.
    localparam int CB_ALU0     = 0;
    localparam int CB_ALU1     = 1;
    localparam int CB_ALU2     = 2;
    localparam int CB_ACC_WE   = 3;
    localparam int CB_B_WE     = 4;
    localparam int CB_MAR_WE   = 5;
    localparam int CB_MEM_RE   = 6;
    localparam int CB_MEM_WE   = 7;
    localparam int CB_OUT_WE   = 8;
    localparam int CB_FLAG_WE  = 9;
    localparam int CB_SEL_IMM  = 10;
    localparam int CB_SEL_MEM  = 11;
    localparam int CB_SHIFT    = 12;
    localparam int CB_CIN      = 13;
    localparam int CB_RSVD     = 14;
    localparam int CB_IO_STB   = 15;

    // First execute cycle; NOP and HALT never reach execute, so their rows are zero.
    localparam cword_t CTRL_A [16] = '{
        16'h0000, 16'h0018, 16'h0060, 16'h0209,
        16'h020A, 16'h020B, 16'h020C, 16'h1208,
        16'h0108, 16'h0408, 16'h0060, 16'h0060,
        16'h0020, 16'h2209, 16'h8000, 16'h0000
    };

    // Second execute cycle, only meaningful for opcodes flagged in LONG_OP.
    localparam cword_t CTRL_B [16] = '{
        16'h0000, 16'h0000, 16'h0848, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0A49, 16'h0A4A,
        16'h0080, 16'h0840, 16'h0000, 16'h0000
    };

    localparam logic [15:0] LONG_OP = 16'h3C04;

    typedef struct packed {
        cword_t ctrl_a;
        cword_t ctrl_b;
        logic   long_op;
        logic   is_halt;
        logic   is_nop;
    } decode_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Program ROM bus: the sequencer presents an address, the ROM answers in the same cycle.
interface program_sequencer_if;
    import sequencer_pkg::*;

    logic [PC_W-1:0] rom_addr;
    logic [OP_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sequencer_decode.sv
// Combinational opcode lookup: control words, long-op flag and special-op flags.
module sequencer_decode
    import sequencer_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output decode_t         dec
);

    always_comb begin
        dec.ctrl_a  = CTRL_A[op];
        dec.ctrl_b  = CTRL_B[op];
        dec.long_op = LONG_OP[op];
        dec.is_halt = (op == OP_HALT);
        dec.is_nop  = (op == OP_NOP);
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/decode/execute sequencer: walks the program ROM and drives the
// datapath control word, with run, single-step, halt and restart.
module program_sequencer
    import sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic                restart,
    program_sequencer_if.master rom,
    output cword_t              control,
    output logic [PC_W-1:0]     PC_out,
    output logic [OP_W-1:0]     IR_out,
    output logic                busy,
    output logic                halted
);

    state_t          state, state_nx, done_nx;
    mode_t           mode, mode_nx;
    logic [PC_W-1:0] pc_nx;
    logic [OP_W-1:0] ir_nx;
    cword_t          ctrl_nx;
    logic            busy_nx;
    logic            halted_nx;
    decode_t         dec;

    sequencer_decode u_decode (
        .op  (IR_out),
        .dec (dec)
    );

    assign rom.rom_addr = PC_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            mode    <= MODE_STEP;
            PC_out  <= '0;
            IR_out  <= '0;
            control <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nx;
            mode    <= mode_nx;
            PC_out  <= pc_nx;
            IR_out  <= ir_nx;
            control <= ctrl_nx;
            busy    <= busy_nx;
            halted  <= halted_nx;
        end
    end

    // Registered outputs are loaded from the next state, so they line up with
    // the state they describe and a restart clears them on the very next edge.
    always_comb begin
        state_nx = state;
        mode_nx  = mode;
        pc_nx    = PC_out;
        ir_nx    = IR_out;
        ctrl_nx  = '0;
        done_nx  = (mode == MODE_RUN && run) ? S_FETCH : S_IDLE;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                    mode_nx  = MODE_RUN;
                end else if (step) begin
                    state_nx = S_FETCH;
                    mode_nx  = MODE_STEP;
                end
            end
            S_FETCH: begin
                ir_nx    = rom.rom_data;
                pc_nx    = (PC_out == PROG_LAST) ? '0 : PC_out + 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (dec.is_halt) begin
                    state_nx = S_HALTED;
                end else if (dec.is_nop) begin
                    state_nx = done_nx;
                end else begin
                    state_nx = S_EXEC1;
                    ctrl_nx  = dec.ctrl_a;
                end
            end
            S_EXEC1: begin
                if (dec.long_op) begin
                    state_nx = S_EXEC2;
                    ctrl_nx  = dec.ctrl_b;
                end else begin
                    state_nx = done_nx;
                end
            end
            S_EXEC2:  state_nx = done_nx;
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase

        if (restart) begin
            state_nx = S_IDLE;
            mode_nx  = MODE_STEP;
            pc_nx    = '0;
            ir_nx    = '0;
            ctrl_nx  = '0;
        end

        busy_nx   = (state_nx == S_FETCH) || (state_nx == S_DECODE) ||
                    (state_nx == S_EXEC1) || (state_nx == S_EXEC2);
        halted_nx = (state_nx == S_HALTED);
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: an instruction-level model predicts
// control words and the end-of-burst state; a monitor checks them as they appear.
module tb_program_sequencer;
    import sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, run, step, restart;
    cword_t      control;
    logic [4:0]  pc_out;
    logic [3:0]  ir_out;
    logic        busy, halted;
    logic [3:0]  rom [32];

    program_sequencer_if rbus ();
    assign rbus.rom_data = rom[rbus.rom_addr];

    program_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .step    (step),
        .restart (restart),
        .rom     (rbus),
        .control (control),
        .PC_out  (pc_out),
        .IR_out  (ir_out),
        .busy    (busy),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int ir;
        int halted;
        int cycles;
    } ret_t;

    cword_t ctrl_q [$];
    ret_t   ret_q [$];
    int     checks = 0;
    int     failures = 0;
    bit     mon_en = 1'b0;
    bit     prev_busy = 1'b0;
    int     busy_cnt = 0;
    int     m_pc = 0;
    bit     m_halted = 1'b0;
    cword_t e_ctrl;
    ret_t   e_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=done", name);
    endtask

    // Monitor: pops an expected control word whenever one is driven, and an
    // expected end state whenever busy drops.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (mon_en) begin
            chk("rom_addr_known", 32'($isunknown(rbus.rom_addr)), 32'd0);
            chk("rom_addr", 32'(rbus.rom_addr), 32'(pc_out));
            if (control != '0) begin
                if (ctrl_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ctrl_unexpected actual=%h required=none", control);
                end else begin
                    e_ctrl = ctrl_q.pop_front();
                    chk("control", 32'(control), 32'(e_ctrl));
                end
            end
            if (prev_busy && !busy) begin
                if (ret_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL busy_fall_unexpected actual=pc%0d required=none", pc_out);
                end else begin
                    e_ret = ret_q.pop_front();
                    chk("done_pc", 32'(pc_out), 32'(e_ret.pc));
                    chk("done_ir", 32'(ir_out), 32'(e_ret.ir));
                    chk("done_halted", 32'(halted), 32'(e_ret.halted));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e_ret.cycles));
                end
            end
        end
        if (!busy) busy_cnt = 0;
        prev_busy = busy;
    end

    // Reference: walk k instructions from m_pc (stopping at HALT) and predict
    // control words, the final PC/IR/halted and the total busy cycle count.
    task automatic issue(input int k, output int t, output int lenk);
        int   op, len;
        ret_t r;
        t = 0;
        lenk = 0;
        op = 0;
        for (int i = 0; i < k; i++) begin
            op = int'(rom[m_pc]);
            m_pc = (m_pc + 1) % 32;
            if (op == 0 || op == 15) len = 2;
            else if (LONG_OP[op]) len = 4;
            else len = 3;
            if (op != 0 && op != 15) begin
                ctrl_q.push_back(CTRL_A[op]);
                if (LONG_OP[op]) ctrl_q.push_back(CTRL_B[op]);
            end
            t += len;
            lenk = len;
            if (op == 15) begin
                m_halted = 1'b1;
                break;
            end
        end
        r.pc = m_pc;
        r.ir = op;
        r.halted = m_halted ? 1 : 0;
        r.cycles = t;
        ret_q.push_back(r);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("wait_idle");
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        m_pc = 0;
        m_halted = 1'b0;
    endtask

    task automatic do_step();
        int t, l;
        @(negedge clk);
        issue(1, t, l);
        step = 1'b1;
        @(negedge clk);
        step = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        step = 1'b0;
        wait_idle(20);
    endtask

    task automatic do_run(input int k, input bit with_step);
        int t, l, m;
        @(negedge clk);
        issue(k, t, l);
        run = 1'b1;
        step = with_step;
        @(negedge clk);
        step = 1'b0;
        m = t - l + int'($urandom_range(0, l - 1));
        repeat (m) @(negedge clk);
        run = 1'b0;
        wait_idle(400);
    endtask

    task automatic halt_check();
        if (m_halted) begin
            @(negedge clk);
            run = 1'b1;
            step = 1'b1;
            repeat (3) @(negedge clk);
            run = 1'b0;
            step = 1'b0;
            @(negedge clk);
            chk("halt_hold", 32'(halted), 32'd1);
            chk("halt_busy", 32'(busy), 32'd0);
            chk("halt_pc", 32'(pc_out), 32'(m_pc));
            do_restart();
            chk("restart_pc", 32'(pc_out), 32'd0);
            chk("restart_ir", 32'(ir_out), 32'd0);
            chk("restart_halted", 32'(halted), 32'd0);
        end
    endtask

    task automatic fill_rom();
        int op;
        for (int i = 0; i < 32; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
            rom[i] = 4'(op);
        end
    endtask

    task automatic wait_ctrl();
        int n = 0;
        while (control == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset = 1'b0;
        run = 1'b0;
        step = 1'b0;
        restart = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_control", 32'(control), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_ir", 32'(ir_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        rom[0] = 4'h1;
        do_step();

        do_restart();
        rom[0] = 4'h2;
        rom[1] = 4'h1;
        do_run(2, 1'b0);

        do_restart();
        rom[0] = 4'h0;
        rom[1] = 4'h0;
        rom[2] = 4'hF;
        do_run(3, 1'b0);
        chk("nop_halt_flag", 32'(m_halted), 32'd1);
        halt_check();

        for (int i = 0; i < 32; i++) rom[i] = 4'h0;
        do_restart();
        do_run(32, 1'b0);
        chk("wrap_pc", 32'(pc_out), 32'd0);

        fill_rom();
        do_restart();
        do_run(3, 1'b1);
        halt_check();

        for (int it = 0; it < 30; it++) begin
            if (it % 10 == 0) fill_rom();
            if ($urandom_range(0, 1) == 1) do_step();
            else do_run(int'($urandom_range(1, 40)), $urandom_range(0, 1) == 1);
            halt_check();
        end

        repeat (2) @(negedge clk);
        chk("ctrl_q_empty", 32'(ctrl_q.size()), 32'd0);
        chk("ret_q_empty", 32'(ret_q.size()), 32'd0);

        mon_en = 1'b0;
        do_restart();
        rom[0] = 4'h3;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_ctrl();
        chk("exec1_ctrl", 32'(control), 32'(CTRL_A[3]));
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_exec1_control", 32'(control), 32'd0);
        chk("rs_exec1_pc", 32'(pc_out), 32'd0);
        chk("rs_exec1_ir", 32'(ir_out), 32'd0);
        chk("rs_exec1_busy", 32'(busy), 32'd0);

        rom[0] = 4'h2;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_ctrl();
        chk("long_exec1_ctrl", 32'(control), 32'(CTRL_A[2]));
        #2 reset = 1'b0;
        #1;
        chk("async_control", 32'(control), 32'd0);
        chk("async_pc", 32'(pc_out), 32'd0);
        chk("async_ir", 32'(ir_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_pc", 32'(pc_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
